// File: rtl/osd_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | osd_loader : command/data word loader driving the osd select/strobe bus  |
// | Optional data-stall timeout: define OSD_LOADER_TIMEOUT_EN                |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module osd_loader #(
   parameter int STB_HIGH  = 1,
   parameter int STB_LOW   = 1,
   parameter int DESEL_CYC = 2,
   parameter int TIMEOUT   = 4095
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd,
   input  logic [12:0] len,
   input  logic        data_valid,
   output logic        data_ready,
   input  logic [15:0] data,
   output logic        io_osd,
   output logic        io_strobe,
   output logic [15:0] io_din,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SEL   = 3'd1,
      ST_CSTB  = 3'd2,
      ST_CGAP  = 3'd3,
      ST_DWAIT = 3'd4,
      ST_DSTB  = 3'd5,
      ST_DGAP  = 3'd6,
      ST_DESEL = 3'd7
   } state_t;

   localparam logic [3:0] c_stb_high_last = 4'(STB_HIGH - 1);
   localparam logic [3:0] c_stb_low_last  = 4'(STB_LOW - 1);
   localparam logic [3:0] c_desel_last    = 4'(DESEL_CYC - 1);

   if (STB_HIGH < 1 || STB_HIGH > 15) begin : g_chk_stb_high
      $error("osd_loader: STB_HIGH out of range 1..15");
   end
   if (STB_LOW < 1 || STB_LOW > 15) begin : g_chk_stb_low
      $error("osd_loader: STB_LOW out of range 1..15");
   end
   if (DESEL_CYC < 2 || DESEL_CYC > 15) begin : g_chk_desel
      $error("osd_loader: DESEL_CYC out of range 2..15");
   end
   if (TIMEOUT < 1) begin : g_chk_timeout
      $error("osd_loader: TIMEOUT must be at least 1");
   end

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [12:0] rem_q, rem_d;
   logic [15:0] io_din_q, io_din_d;
   logic        io_osd_q, io_osd_d;
   logic        io_strobe_q, io_strobe_d;
   logic        cmd_ready_q, cmd_ready_d;
   logic        data_ready_q, data_ready_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        w_cmd_acc;
   logic        w_data_acc;

`ifdef OSD_LOADER_TIMEOUT_EN
   localparam int c_stall_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_stall_w-1:0] c_stall_last = c_stall_w'(TIMEOUT - 1);

   logic [c_stall_w-1:0] stall_q, stall_d;
   logic                 abort_q, abort_d;
   logic                 err_q, err_d;
`endif

   assign w_cmd_acc  = cmd_valid & cmd_ready_q;
   assign w_data_acc = data_valid & data_ready_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      io_din_d = io_din_q;
      done_d   = 1'b0;
`ifdef OSD_LOADER_TIMEOUT_EN
      stall_d  = stall_q;
      abort_d  = abort_q;
      err_d    = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (w_cmd_acc) begin
               io_din_d = {8'h00, cmd};
               rem_d    = len;
               cnt_d    = '0;
               state_d  = ST_SEL;
`ifdef OSD_LOADER_TIMEOUT_EN
               stall_d  = '0;
               abort_d  = 1'b0;
`endif
            end
         end
         ST_SEL: begin
            cnt_d   = '0;
            state_d = ST_CSTB;
         end
         ST_CSTB, ST_DSTB: begin
            if (cnt_q == c_stb_high_last) begin
               cnt_d   = '0;
               state_d = (state_q == ST_CSTB) ? ST_CGAP : ST_DGAP;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_CGAP, ST_DGAP: begin
            if (cnt_q == c_stb_low_last) begin
               cnt_d   = '0;
               state_d = (rem_q != 13'd0) ? ST_DWAIT : ST_DESEL;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_DWAIT: begin
            if (w_data_acc) begin
               io_din_d = data;
               rem_d    = rem_q - 13'd1;
               state_d  = ST_DSTB;
`ifdef OSD_LOADER_TIMEOUT_EN
               stall_d  = '0;
`endif
            end
`ifdef OSD_LOADER_TIMEOUT_EN
            else if (stall_q == c_stall_last) begin
               // Abandon the rest of the burst; DESEL still closes the frame.
               stall_d = '0;
               rem_d   = '0;
               abort_d = 1'b1;
               cnt_d   = '0;
               state_d = ST_DESEL;
            end else begin
               stall_d = stall_q + 1'b1;
            end
`endif
         end
         ST_DESEL: begin
            if (cnt_q == c_desel_last) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
`ifdef OSD_LOADER_TIMEOUT_EN
               done_d  = ~abort_q;
               err_d   = abort_q;
               abort_d = 1'b0;
`else
               done_d  = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      cmd_ready_d  = (state_d == ST_IDLE);
      data_ready_d = (state_d == ST_DWAIT);
      busy_d       = (state_d != ST_IDLE);
      // Select and strobe trail the state by one cycle: io_din is then settled
      // a cycle before each strobe rise, and io_osd stays up for the first
      // DESEL cycle; the IDLE cycle after DESEL restores the full low time.
      io_osd_d     = w_cmd_acc | ((state_q != ST_IDLE) & (state_q != ST_DESEL));
      io_strobe_d  = (state_q == ST_CSTB) | (state_q == ST_DSTB);
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         rem_q        <= '0;
         io_din_q     <= '0;
         io_osd_q     <= 1'b0;
         io_strobe_q  <= 1'b0;
         cmd_ready_q  <= 1'b1;
         data_ready_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
`ifdef OSD_LOADER_TIMEOUT_EN
         stall_q      <= '0;
         abort_q      <= 1'b0;
         err_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rem_q        <= rem_d;
         io_din_q     <= io_din_d;
         io_osd_q     <= io_osd_d;
         io_strobe_q  <= io_strobe_d;
         cmd_ready_q  <= cmd_ready_d;
         data_ready_q <= data_ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
`ifdef OSD_LOADER_TIMEOUT_EN
         stall_q      <= stall_d;
         abort_q      <= abort_d;
         err_q        <= err_d;
`endif
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign data_ready = data_ready_q;
   assign io_osd     = io_osd_q;
   assign io_strobe  = io_strobe_q;
   assign io_din     = io_din_q;
   assign busy       = busy_q;
   assign done       = done_q;
`ifdef OSD_LOADER_TIMEOUT_EN
   assign err        = err_q;
`else
   assign err        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_osd_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_osd_loader : self-checking bench for osd_loader (two configurations)  |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_osd_loader;

   typedef struct {
      int          inst;
      logic [7:0]  c;
      int          n;
      int          n_sup;
      int          exp_osd;
      logic [15:0] w   [8];
      int          gap [8];
   } vec_t;

   localparam int c_to1 = 16;

   logic clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   logic        reset_n    [2];
   logic        cmd_valid  [2];
   logic [7:0]  cmd        [2];
   logic [12:0] len        [2];
   logic        data_valid [2];
   logic [15:0] data       [2];
   logic        cmd_ready  [2];
   logic        data_ready [2];
   logic        io_osd     [2];
   logic        io_strobe  [2];
   logic [15:0] io_din     [2];
   logic        busy       [2];
   logic        done       [2];
   logic        err        [2];

   osd_loader u_dut0 (
      .clk_sys(clk_sys), .reset_n(reset_n[0]),
      .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd(cmd[0]), .len(len[0]),
      .data_valid(data_valid[0]), .data_ready(data_ready[0]), .data(data[0]),
      .io_osd(io_osd[0]), .io_strobe(io_strobe[0]), .io_din(io_din[0]),
      .busy(busy[0]), .done(done[0]), .err(err[0])
   );

   osd_loader #(.STB_HIGH(3), .STB_LOW(2), .DESEL_CYC(3), .TIMEOUT(c_to1)) u_dut1 (
      .clk_sys(clk_sys), .reset_n(reset_n[1]),
      .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd(cmd[1]), .len(len[1]),
      .data_valid(data_valid[1]), .data_ready(data_ready[1]), .data(data[1]),
      .io_osd(io_osd[1]), .io_strobe(io_strobe[1]), .io_din(io_din[1]),
      .busy(busy[1]), .done(done[1]), .err(err[1])
   );

   int e_hi    [2] = '{1, 3};
   int e_lo    [2] = '{1, 2};
   int e_desel [2] = '{2, 3};

   int n_vec  = 0;
   int n_fail = 0;

   // Per-transaction observations, gathered on the falling edge.
   int          m_done [2], m_err [2], m_hs [2], m_stall [2], m_osd_hi [2], m_falls [2];
   int          m_inv [2], m_stab [2], m_hi [2], m_lo [2], m_nobs [2];
   int          m_hilen [2], m_lolen [2], m_osdlo [2], m_lo2done [2];
   logic [15:0] m_obs [2][32];
   logic        p_strobe [2], p_osd [2];
   logic [15:0] p_din [2];

   always @(negedge clk_sys) begin
      for (int k = 0; k < 2; k++) begin
         if (io_strobe[k] && !io_osd[k]) m_inv[k]++;
         if (cmd_ready[k] && busy[k]) m_inv[k]++;
         if (data_ready[k] && !busy[k]) m_inv[k]++;
         if (io_osd[k] && !p_osd[k] && m_osdlo[k] < e_desel[k]) m_inv[k]++;
         if (!io_osd[k] && p_osd[k]) m_falls[k]++;
         if (io_osd[k]) m_osd_hi[k]++;
         m_osdlo[k] = io_osd[k] ? 0 : m_osdlo[k] + 1;
         if (done[k] || err[k]) m_lo2done[k] = m_osdlo[k];
         if (done[k]) m_done[k]++;
         if (err[k]) m_err[k]++;
         if (data_valid[k] && data_ready[k]) m_hs[k]++;
         if (!data_valid[k] && data_ready[k]) m_stall[k]++;
         if (io_strobe[k] && !p_strobe[k]) begin
            if (!p_osd[k]) m_inv[k]++;
            if (io_din[k] != p_din[k]) m_stab[k]++;
            if (m_nobs[k] > 0 && m_lolen[k] < e_lo[k]) m_lo[k]++;
            if (m_nobs[k] < 32) m_obs[k][m_nobs[k]] = io_din[k];
            m_nobs[k]++;
            m_hilen[k] = 1;
         end else if (io_strobe[k]) begin
            m_hilen[k]++;
            if (io_din[k] != p_din[k]) m_stab[k]++;
         end else if (p_strobe[k]) begin
            if (m_hilen[k] != e_hi[k]) m_hi[k]++;
            m_lolen[k] = 1;
         end else begin
            m_lolen[k]++;
         end
         p_strobe[k] = io_strobe[k];
         p_osd[k]    = io_osd[k];
         p_din[k]    = io_din[k];
      end
   end

   function automatic void chk(input string nm, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endfunction

   task automatic clr(input int k);
      m_done[k] = 0; m_err[k] = 0; m_hs[k] = 0; m_stall[k] = 0; m_osd_hi[k] = 0;
      m_falls[k] = 0; m_inv[k] = 0; m_stab[k] = 0; m_hi[k] = 0; m_lo[k] = 0;
      m_nobs[k] = 0; m_hilen[k] = 0; m_lolen[k] = 0; m_lo2done[k] = -1;
   endtask

   function automatic vec_t mk(input int inst, input logic [7:0] c, input int n);
      vec_t v;
      v.inst = inst; v.c = c; v.n = n; v.n_sup = n; v.exp_osd = -1;
      for (int i = 0; i < 8; i++) begin
         v.w[i]   = 16'(i);
         v.gap[i] = 0;
      end
      return v;
   endfunction

   // Reference behaviour: one strobe carrying the command, then one per supplied
   // word in order; a normal finish pulses done, a short supply ends in err.
   task automatic run_txn(input vec_t v, input string tag);
      int   k;
      logic ok;
      logic [15:0] exp_w;
      logic exp_done;
      k = v.inst;
      exp_done = (v.n_sup >= v.n);
      clr(k);
      @(posedge clk_sys); #1;
      cmd[k] = v.c; len[k] = 13'(v.n); cmd_valid[k] = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 100 && !ok; t++) begin
         @(negedge clk_sys);
         ok = cmd_ready[k];
      end
      chk($sformatf("%s cmd_accept", tag), ok, 1);
      @(posedge clk_sys); #1;
      cmd_valid[k] = 1'b0; cmd[k] = 8'($urandom); len[k] = 13'($urandom);
      for (int i = 0; i < v.n_sup; i++) begin
         data_valid[k] = 1'b0;
         repeat (v.gap[i]) begin
            @(posedge clk_sys); #1;
         end
         data_valid[k] = 1'b1; data[k] = v.w[i];
         ok = 1'b0;
         for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk_sys);
            ok = data_ready[k];
         end
         if (!ok) chk($sformatf("%s data_accept%0d", tag, i), ok, 1);
         @(posedge clk_sys); #1;
         data_valid[k] = 1'b0; data[k] = 16'($urandom);
      end
      ok = 1'b0;
      for (int t = 0; t < 400 && !ok; t++) begin
         @(negedge clk_sys);
         ok = done[k] | err[k];
      end
      chk($sformatf("%s end_pulse", tag), ok, 1);
      @(negedge clk_sys); #1;
      chk($sformatf("%s strobes", tag), m_nobs[k], 1 + v.n_sup);
      for (int i = 0; i <= v.n_sup && i < m_nobs[k]; i++) begin
         exp_w = (i == 0) ? {8'h00, v.c} : v.w[i-1];
         chk($sformatf("%s word%0d", tag, i), m_obs[k][i], exp_w);
      end
      chk($sformatf("%s done", tag), m_done[k], exp_done ? 1 : 0);
      chk($sformatf("%s err", tag), m_err[k], exp_done ? 0 : 1);
      chk($sformatf("%s handshakes", tag), m_hs[k], v.n_sup);
      chk($sformatf("%s osd_falls", tag), m_falls[k], 1);
      chk($sformatf("%s invariants", tag), m_inv[k], 0);
      chk($sformatf("%s din_stable", tag), m_stab[k], 0);
      chk($sformatf("%s strobe_high", tag), m_hi[k], 0);
      chk($sformatf("%s strobe_low", tag), m_lo[k], 0);
      chk($sformatf("%s desel_low", tag), m_lo2done[k], e_desel[k]);
      if (!exp_done) chk($sformatf("%s stall_cycles", tag), m_stall[k], c_to1);
      if (v.exp_osd >= 0) chk($sformatf("%s osd_high", tag), m_osd_hi[k], v.exp_osd);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      vec_t tbl [5];
      int   n_tbl;
      vec_t v;
      logic ok;

      tbl[0] = mk(0, 8'h41, 0);
      tbl[0].exp_osd = 4;
      tbl[1] = mk(0, 8'h20, 3);
      tbl[1].w[0] = 16'h00AA; tbl[1].w[1] = 16'h0055; tbl[1].w[2] = 16'h000F;
      tbl[2] = mk(0, 8'h40, 5);
      for (int i = 0; i < 5; i++) tbl[2].w[i] = 16'h0101 * 16'(i + 1);
      tbl[2].gap[2] = 10;
      tbl[3] = mk(1, 8'h22, 1);
      tbl[3].w[0] = 16'hBEEF;
      n_tbl = 4;
`ifdef OSD_LOADER_TIMEOUT_EN
      tbl[4] = mk(1, 8'h21, 2);
      tbl[4].n_sup = 1; tbl[4].w[0] = 16'h00C3;
      n_tbl = 5;
`endif

      for (int k = 0; k < 2; k++) begin
         reset_n[k] = 1'b0; cmd_valid[k] = 1'b0; cmd[k] = '0; len[k] = '0;
         data_valid[k] = 1'b0; data[k] = '0;
         m_osdlo[k] = 100; p_strobe[k] = 1'b0; p_osd[k] = 1'b0; p_din[k] = '0;
         clr(k);
      end
      repeat (3) @(negedge clk_sys);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("u%0d rst io_osd", k), io_osd[k], 0);
         chk($sformatf("u%0d rst io_strobe", k), io_strobe[k], 0);
         chk($sformatf("u%0d rst io_din", k), io_din[k], 0);
         chk($sformatf("u%0d rst busy", k), busy[k], 0);
         chk($sformatf("u%0d rst done_err", k), {done[k], err[k]}, 0);
         chk($sformatf("u%0d rst data_ready", k), data_ready[k], 0);
         reset_n[k] = 1'b1;
      end
      @(negedge clk_sys);
      for (int k = 0; k < 2; k++) chk($sformatf("u%0d rst cmd_ready", k), cmd_ready[k], 1);

      for (int i = 0; i < n_tbl; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

      // Reset while the second data word is being strobed.
      clr(0);
      @(posedge clk_sys); #1;
      cmd[0] = 8'h20; len[0] = 13'd3; cmd_valid[0] = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin @(negedge clk_sys); ok = cmd_ready[0]; end
      @(posedge clk_sys); #1;
      cmd_valid[0] = 1'b0; data_valid[0] = 1'b1; data[0] = 16'h00AA;
      for (int w = 0; w < 2; w++) begin
         ok = 1'b0;
         for (int t = 0; t < 50 && !ok; t++) begin @(negedge clk_sys); ok = data_ready[0]; end
         chk($sformatf("rstseq data_accept%0d", w), ok, 1);
         @(posedge clk_sys); #1;
         data[0] = 16'h0055;
      end
      #1;
      reset_n[0] = 1'b0;
      #1;
      chk("rstseq io_osd", io_osd[0], 0);
      chk("rstseq io_strobe", io_strobe[0], 0);
      chk("rstseq busy", busy[0], 0);
      data_valid[0] = 1'b0;
      @(negedge clk_sys);
      reset_n[0] = 1'b1;
      @(negedge clk_sys);
      chk("rstseq cmd_ready", cmd_ready[0], 1);
      v = mk(0, 8'h41, 1);
      v.w[0] = 16'h1234;
      run_txn(v, "post_rst");

      for (int r = 0; r < 24; r++) begin
         v = mk(r % 2, 8'($urandom), int'($urandom_range(0, 6)));
         for (int i = 0; i < 8; i++) begin
            v.w[i]   = 16'($urandom);
            v.gap[i] = int'($urandom_range(0, 3));
         end
         run_txn(v, $sformatf("rnd%0d", r));
         repeat ($urandom_range(0, 2)) @(posedge clk_sys);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
